// File: rtl/hilo_div_ctrl_if.sv
// hilo_div_ctrl_if: bundles the control-unit request/status signals, the
// architectural HI/LO outputs and the divider-side operand/result signals.
//   start_div/mthi/mtlo, rs_val, rt_val : requests from the control unit
//   busy, done, div_zero, hi, lo        : status and HI/LO back to the control unit
//   div_a, div_b, div_init              : operands and start pulse to the divider
//   div_hi, div_lo                      : remainder / quotient from the divider
// slave  = the sequencer's view, master = the control unit / divider side.
interface hilo_div_ctrl_if;
  logic        start_div;
  logic        mthi;
  logic        mtlo;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_init;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport slave (
    input  start_div, mthi, mtlo, rs_val, rt_val, div_hi, div_lo,
    output div_a, div_b, div_init, busy, done, div_zero, hi, lo
  );

  modport master (
    output start_div, mthi, mtlo, rs_val, rt_val, div_hi, div_lo,
    input  div_a, div_b, div_init, busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: sequencer and HI/LO holder in front of the iterative divider.
// Screens divide requests for a zero divisor, latches operands, pulses the
// divider start, waits DIV_CYCLES cycles and captures remainder/quotient into
// HI/LO. Also services MTHI/MTLO writes while idle.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : hilo_div_ctrl_if.slave (requests, status, HI/LO, divider signals)
module hilo_div_ctrl #(
  parameter int unsigned DIV_CYCLES = 34
) (
  input  logic           clk,
  input  logic           reset,
  hilo_div_ctrl_if.slave bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_div_a;
  logic [DW-1:0]   r_div_b;
  logic [DW-1:0]   r_hi;
  logic [DW-1:0]   r_lo;
  logic            r_done;
  logic            r_div_zero;
  logic            w_busy;
  logic            w_div_init;

  // Sequencer: idle/launch/wait with HI/LO capture and move handling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_div_a    <= '0;
      r_div_b    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A divide request wins; a move in the same cycle is dropped.
          if (bus.start_div) begin
            if (bus.rt_val == '0) begin
              r_div_zero <= 1'b1;
            end else begin
              r_div_a <= bus.rs_val;
              r_div_b <= bus.rt_val;
              r_state <= S_LAUNCH;
            end
          end else begin
            if (bus.mthi) r_hi <= bus.rs_val;
            if (bus.mtlo) r_lo <= bus.rs_val;
          end
        end
        S_LAUNCH: begin
          r_cnt   <= CW'(DIV_CYCLES - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Results are valid in the cycle the counter reads zero.
          if (r_cnt == '0) begin
            r_hi    <= bus.div_hi;
            r_lo    <= bus.div_lo;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Status decoded straight from state so they drop as soon as reset hits.
  assign w_busy     = (r_state != S_IDLE);
  assign w_div_init = (r_state == S_LAUNCH);

  assign bus.busy     = w_busy;
  assign bus.div_init = w_div_init;
  assign bus.div_a    = r_div_a;
  assign bus.div_b    = r_div_b;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl: scoreboard bench for hilo_div_ctrl. Stimulus pushes the
// expected event (cycle, flags, HI/LO, operands) into a queue; a monitor pops
// and compares whenever the DUT shows div_init, done, div_zero or a HI/LO
// change. A second instance with DIV_CYCLES=1 covers the shortest wait.
module tb_hilo_div_ctrl;

  localparam int unsigned DIVC = 34;

  localparam logic [2:0] K_INIT = 3'b100;
  localparam logic [2:0] K_DONE = 3'b010;
  localparam logic [2:0] K_DZ   = 3'b001;
  localparam logic [2:0] K_MOVE = 3'b000;

  typedef struct {
    logic [2:0]  kind;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errs;
  exp_t sb[$];

  hilo_div_ctrl_if bus ();
  hilo_div_ctrl_if bus1 ();

  hilo_div_ctrl #(.DIV_CYCLES(DIVC)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  hilo_div_ctrl #(.DIV_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: results valid only in the cycle DIVC-1 cycles after init.
  logic       m_run;
  logic [5:0] m_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run <= 1'b0;
      m_cnt <= '0;
    end else if (bus.div_init) begin
      m_run <= 1'b1;
      m_cnt <= 6'(DIVC - 1);
    end else if (m_run && m_cnt != 0) begin
      m_cnt <= m_cnt - 6'd1;
    end else if (m_run) begin
      m_run <= 1'b0;
    end
  end

  always_comb begin
    bus.div_hi = 32'hBAD0BAD0;
    bus.div_lo = 32'hBAD0BAD0;
    if (m_run && m_cnt == 0 && bus.div_b != 0) begin
      bus.div_hi = bus.div_a % bus.div_b;
      bus.div_lo = bus.div_a / bus.div_b;
    end
  end

  always_comb begin
    bus1.div_hi = '0;
    bus1.div_lo = '0;
    if (bus1.div_b != 0) begin
      bus1.div_hi = bus1.div_a % bus1.div_b;
      bus1.div_lo = bus1.div_a / bus1.div_b;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void push(input logic [2:0] k, input int c, input logic [31:0] h,
                               input logic [31:0] l, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.kind = k; e.cyc = c; e.hi = h; e.lo = l; e.a = a; e.b = b;
    sb.push_back(e);
  endfunction

  // Monitor
  logic [31:0] prev_hi, prev_lo;
  int          busy_cnt;
  exp_t        me;
  always @(negedge clk) begin
    if (!reset) begin
      prev_hi  = bus.hi;
      prev_lo  = bus.lo;
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.div_init || bus.done || bus.div_zero || bus.hi !== prev_hi || bus.lo !== prev_lo) begin
        if (sb.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_event at cycle %0d: init=%b done=%b dz=%b hi=%h lo=%h, expected no event",
                   cyc, bus.div_init, bus.done, bus.div_zero, bus.hi, bus.lo);
        end else begin
          me = sb.pop_front();
          chk("event_flags", {29'b0, bus.div_init, bus.done, bus.div_zero}, {29'b0, me.kind});
          chk("event_cycle", 32'(cyc), 32'(me.cyc));
          chk("hi", bus.hi, me.hi);
          chk("lo", bus.lo, me.lo);
          chk("div_a", bus.div_a, me.a);
          chk("div_b", bus.div_b, me.b);
          chk("busy", {31'b0, bus.busy}, {31'b0, (me.kind == K_INIT)});
          if (me.kind == K_DONE) begin
            chk("busy_cycles", 32'(busy_cnt), 32'(DIVC + 1));
            busy_cnt = 0;
          end
        end
      end
      prev_hi = bus.hi;
      prev_lo = bus.lo;
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic h, input logic l,
                       input logic [31:0] rs, input logic [31:0] rt);
    bus.start_div = s; bus.mthi = h; bus.mtlo = l;
    bus.rs_val = rs; bus.rt_val = rt;
    @(negedge clk);
    bus.start_div = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    bus.rs_val = '0; bus.rt_val = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int c0, c1;
  initial begin
    checks = 0;
    errs   = 0;
    reset  = 1'b0;
    bus.start_div = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    bus.rs_val = '0; bus.rt_val = '0;
    bus1.start_div = 1'b0; bus1.mthi = 1'b0; bus1.mtlo = 1'b0;
    bus1.rs_val = '0; bus1.rt_val = '0;
    #1;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_done", {31'b0, bus.done}, 32'h0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    // Reset in the middle of a wait: everything clears, no done afterwards.
    c0 = cyc;
    push(K_INIT, c0 + 1, 32'h0, 32'h0, 32'd77, 32'd5);
    drive(1'b1, 1'b0, 1'b0, 32'd77, 32'd5);
    wait_cyc(c0 + 10);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {31'b0, bus.busy}, 32'h0);
    chk("abort_init", {31'b0, bus.div_init}, 32'h0);
    chk("abort_div_a", bus.div_a, 32'h0);
    chk("abort_div_b", bus.div_b, 32'h0);
    chk("abort_hi", bus.hi, 32'h0);
    chk("abort_lo", bus.lo, 32'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (45) @(negedge clk);

    // 100/7 then 50/4 issued in the done cycle.
    c0 = cyc;
    push(K_INIT, c0 + 1, 32'h0, 32'h0, 32'd100, 32'd7);
    push(K_DONE, c0 + 36, 32'd2, 32'd14, 32'd100, 32'd7);
    drive(1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    wait_cyc(c0 + 36);
    c1 = cyc;
    push(K_INIT, c1 + 1, 32'd2, 32'd14, 32'd50, 32'd4);
    push(K_DONE, c1 + 36, 32'd2, 32'd12, 32'd50, 32'd4);
    drive(1'b1, 1'b0, 1'b0, 32'd50, 32'd4);
    wait_cyc(c1 + 38);

    // Zero divisor, then a move accepted in the div_zero cycle.
    c0 = cyc;
    push(K_DZ, c0 + 1, 32'd2, 32'd12, 32'd50, 32'd4);
    drive(1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
    push(K_MOVE, c0 + 2, 32'hDEADBEEF, 32'd12, 32'd50, 32'd4);
    drive(1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'd0);
    c0 = cyc;
    push(K_MOVE, c0 + 1, 32'hDEADBEEF, 32'h12345678, 32'd50, 32'd4);
    drive(1'b0, 1'b0, 1'b1, 32'h12345678, 32'd0);
    c0 = cyc;
    push(K_MOVE, c0 + 1, 32'hCAFEF00D, 32'hCAFEF00D, 32'd50, 32'd4);
    drive(1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 32'd0);
    repeat (3) @(negedge clk);

    // start_div with mthi in the same cycle; requests during busy are ignored.
    c0 = cyc;
    push(K_INIT, c0 + 1, 32'hCAFEF00D, 32'hCAFEF00D, 32'd9, 32'd3);
    push(K_DONE, c0 + 36, 32'd0, 32'd3, 32'd9, 32'd3);
    drive(1'b1, 1'b1, 1'b0, 32'd9, 32'd3);
    wait_cyc(c0 + 5);
    drive(1'b1, 1'b1, 1'b1, 32'hAAAA5555, 32'd1);
    wait_cyc(c0 + 10);
    drive(1'b0, 1'b0, 1'b1, 32'h11111111, 32'd0);
    wait_cyc(c0 + 38);

    // Shortest wait: DIV_CYCLES=1 gives done in cycle 3.
    bus1.start_div = 1'b1; bus1.rs_val = 32'd20; bus1.rt_val = 32'd6;
    @(negedge clk);
    bus1.start_div = 1'b0; bus1.rs_val = '0; bus1.rt_val = '0;
    chk("dc1_init_c1", {31'b0, bus1.div_init}, 32'h1);
    chk("dc1_busy_c1", {31'b0, bus1.busy}, 32'h1);
    @(negedge clk);
    chk("dc1_init_c2", {31'b0, bus1.div_init}, 32'h0);
    chk("dc1_busy_c2", {31'b0, bus1.busy}, 32'h1);
    chk("dc1_done_c2", {31'b0, bus1.done}, 32'h0);
    @(negedge clk);
    chk("dc1_done_c3", {31'b0, bus1.done}, 32'h1);
    chk("dc1_busy_c3", {31'b0, bus1.busy}, 32'h0);
    chk("dc1_hi", bus1.hi, 32'd2);
    chk("dc1_lo", bus1.lo, 32'd3);
    @(negedge clk);
    chk("dc1_done_c4", {31'b0, bus1.done}, 32'h0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
